// File: rtl/lc3_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package     : lc3_pkg                                                 |
// | Description : Shared LC-3 datapath constants and the condition-code   |
// |               helper used at writeback.                               |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package lc3_pkg;

  // Bit positions inside the {N,Z,P} condition-code vector
  localparam int NZP_N_BIT = 2;
  localparam int NZP_Z_BIT = 1;
  localparam int NZP_P_BIT = 0;

  // Architectural reset value of the condition codes (Z set)
  localparam logic [2:0] NZP_ZERO = 3'b010;

  // Widest data word the helper accepts; callers zero-extend narrower words
  localparam int CC_MAX_W = 64;

  // Condition codes of a word whose significant width is 'width' bits.
  // Upper bits beyond 'width' must be zero so the Z test stays exact.
  function automatic logic [2:0] cc_from_value(input logic [CC_MAX_W-1:0] value,
                                               input int                   width);
    logic [2:0] cc;
    logic       neg;
    logic       zero;
    neg           = value[width-1];
    zero          = (value == '0);
    cc            = '0;
    cc[NZP_N_BIT] = neg;
    cc[NZP_Z_BIT] = zero;
    cc[NZP_P_BIT] = !neg && !zero;
    return cc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : reg_scoreboard                                          |
// | Description : Per-register busy bits tracking in-flight writes, with  |
// |               issue-over-clear priority and writeback masking of the  |
// |               read-port busy flags.                                   |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module reg_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_dr,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic                rd_busy1,
  output logic                rd_busy2,
  output logic [NUM_REGS-1:0] busy_vec
);

  // One extra bit so NUM_REGS == 2**ADDR_W is still representable
  localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                rd_ok1;
  logic                rd_ok2;

  // Issue wins over a same-cycle writeback so the newer in-flight write stays tracked;
  // out-of-range issue/write addresses match no register and are therefore ignored
  always_comb begin
    busy_next = busy;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (issue_en && issue_dr == ADDR_W'(r)) begin
        busy_next[r] = 1'b1;
      end else if (wr_en && wr_addr == ADDR_W'(r)) begin
        busy_next[r] = 1'b0;
      end
    end
  end

  // Busy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // A writeback in flight this cycle is bypassed, so it masks the busy flag
  always_comb begin
    rd_ok1   = ({1'b0, rd_addr1} < NUM_REGS_EXT);
    rd_ok2   = ({1'b0, rd_addr2} < NUM_REGS_EXT);
    rd_busy1 = 1'b0;
    rd_busy2 = 1'b0;
    if (rd_ok1) begin
      rd_busy1 = busy[rd_addr1] && !(wr_en && wr_addr == rd_addr1);
    end
    if (rd_ok2) begin
      rd_busy2 = busy[rd_addr2] && !(wr_en && wr_addr == rd_addr2);
    end
  end

  assign busy_vec = busy;

endmodule
`default_nettype wire

// File: rtl/pipe_reg_file.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : pipe_reg_file                                           |
// | Description : LC-3 pipelined register file: data array with           |
// |               write-to-read bypass, busy scoreboard and NZP register. |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module pipe_reg_file
  import lc3_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                NUM_REGS  = 8,
  parameter int                ADDR_W    = $clog2(NUM_REGS),
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                cc_en,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_dr,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                rd_busy1,
  output logic                rd_busy2,
  output logic [2:0]          nzp,
  output logic [NUM_REGS-1:0] busy_vec
);

  // DATA_W must not exceed CC_MAX_W for the condition-code helper
  localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;
  logic              rd_ok1;
  logic              rd_ok2;

  assign wr_ok  = ({1'b0, wr_addr}  < NUM_REGS_EXT);
  assign rd_ok1 = ({1'b0, rd_addr1} < NUM_REGS_EXT);
  assign rd_ok2 = ({1'b0, rd_addr2} < NUM_REGS_EXT);

  // Register array: writes to addresses past the last register are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (wr_en && wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Condition codes follow every cc-enabled writeback, even to an unmapped address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzp <= NZP_ZERO;
    end else if (wr_en && cc_en) begin
      nzp <= cc_from_value(CC_MAX_W'(wr_data), DATA_W);
    end
  end

  // Read port 1: unmapped address reads zero, otherwise bypass a same-cycle write
  always_comb begin
    rd_data1 = '0;
    if (rd_ok1) begin
      rd_data1 = (wr_en && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1];
    end
  end

  // Read port 2: same selection as port 1
  always_comb begin
    rd_data2 = '0;
    if (rd_ok2) begin
      rd_data2 = (wr_en && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2];
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .issue_en (issue_en),
    .issue_dr (issue_dr),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_busy1 (rd_busy1),
    .rd_busy2 (rd_busy2),
    .busy_vec (busy_vec)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_file.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_pipe_reg_file                                        |
// | Description : Scoreboard bench for pipe_reg_file: directed vectors on |
// |               an 8x16 and a 6x16 instance, reference-model sweep on a |
// |               16x32 instance.                                         |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_pipe_reg_file;

  localparam bit [5:0] M_D1  = 6'b000001;
  localparam bit [5:0] M_D2  = 6'b000010;
  localparam bit [5:0] M_B1  = 6'b000100;
  localparam bit [5:0] M_B2  = 6'b001000;
  localparam bit [5:0] M_NZP = 6'b010000;
  localparam bit [5:0] M_BV  = 6'b100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the 8-register (A) and 6-register (B) instances
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        cc_en = 1'b0;
  logic        issue_en = 1'b0;
  logic [2:0]  issue_dr = '0;
  logic [2:0]  rd_addr1 = '0;
  logic [2:0]  rd_addr2 = '0;

  logic [15:0] a_rd_data1, a_rd_data2, b_rd_data1, b_rd_data2;
  logic        a_rd_busy1, a_rd_busy2, b_rd_busy1, b_rd_busy2;
  logic [2:0]  a_nzp, b_nzp;
  logic [7:0]  a_busy_vec;
  logic [5:0]  b_busy_vec;

  // Stimulus for the 16x32 instance (C)
  logic        c_rst_n = 1'b0;
  logic        c_wr_en = 1'b0;
  logic [3:0]  c_wr_addr = '0;
  logic [31:0] c_wr_data = '0;
  logic        c_cc_en = 1'b0;
  logic        c_issue_en = 1'b0;
  logic [3:0]  c_issue_dr = '0;
  logic [3:0]  c_rd_addr1 = '0;
  logic [3:0]  c_rd_addr2 = '0;
  logic [31:0] c_rd_data1, c_rd_data2;
  logic        c_rd_busy1, c_rd_busy2;
  logic [2:0]  c_nzp;
  logic [15:0] c_busy_vec;

  pipe_reg_file dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cc_en(cc_en), .issue_en(issue_en), .issue_dr(issue_dr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(a_rd_data1), .rd_data2(a_rd_data2),
    .rd_busy1(a_rd_busy1), .rd_busy2(a_rd_busy2),
    .nzp(a_nzp), .busy_vec(a_busy_vec)
  );

  pipe_reg_file #(.DATA_W(16), .NUM_REGS(6), .ADDR_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cc_en(cc_en), .issue_en(issue_en), .issue_dr(issue_dr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_rd_data1), .rd_data2(b_rd_data2),
    .rd_busy1(b_rd_busy1), .rd_busy2(b_rd_busy2),
    .nzp(b_nzp), .busy_vec(b_busy_vec)
  );

  pipe_reg_file #(.DATA_W(32), .NUM_REGS(16)) dut_c (
    .clk(clk), .rst_n(c_rst_n), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .cc_en(c_cc_en), .issue_en(c_issue_en), .issue_dr(c_issue_dr),
    .rd_addr1(c_rd_addr1), .rd_addr2(c_rd_addr2),
    .rd_data1(c_rd_data1), .rd_data2(c_rd_data2),
    .rd_busy1(c_rd_busy1), .rd_busy2(c_rd_busy2),
    .nzp(c_nzp), .busy_vec(c_busy_vec)
  );

  typedef struct {
    string       nm;
    bit          sel_b;
    bit [5:0]    m;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        b1;
    logic        b2;
    logic [2:0]  nzp;
    logic [7:0]  bv;
  } exp_t;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic [2:0]  nzp;
    logic [15:0] bv;
  } cexp_t;

  exp_t  q_ab[$];
  cexp_t q_c[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic rn, input logic we, input logic [2:0] wa,
                     input logic [15:0] wd, input logic ce, input logic ie,
                     input logic [2:0] dr, input logic [2:0] a1, input logic [2:0] a2);
    @(posedge clk);
    #1;
    rst_n = rn; wr_en = we; wr_addr = wa; wr_data = wd; cc_en = ce;
    issue_en = ie; issue_dr = dr; rd_addr1 = a1; rd_addr2 = a2;
  endtask

  task automatic exp_ab(input string nm, input bit sel_b, input bit [5:0] m,
                        input logic [15:0] d1, input logic [15:0] d2,
                        input logic b1, input logic b2,
                        input logic [2:0] nzp, input logic [7:0] bv);
    exp_t e;
    e.nm = nm; e.sel_b = sel_b; e.m = m; e.d1 = d1; e.d2 = d2;
    e.b1 = b1; e.b2 = b2; e.nzp = nzp; e.bv = bv;
    q_ab.push_back(e);
  endtask

  // Monitor for instances A/B: compares the masked fields of each queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_ab.size() > 0) begin
        e = q_ab.pop_front();
        if (e.m[0]) chk({e.nm, ".d1"}, 32'(e.sel_b ? b_rd_data1 : a_rd_data1), 32'(e.d1));
        if (e.m[1]) chk({e.nm, ".d2"}, 32'(e.sel_b ? b_rd_data2 : a_rd_data2), 32'(e.d2));
        if (e.m[2]) chk({e.nm, ".busy1"}, 32'(e.sel_b ? b_rd_busy1 : a_rd_busy1), 32'(e.b1));
        if (e.m[3]) chk({e.nm, ".busy2"}, 32'(e.sel_b ? b_rd_busy2 : a_rd_busy2), 32'(e.b2));
        if (e.m[4]) chk({e.nm, ".nzp"}, 32'(e.sel_b ? b_nzp : a_nzp), 32'(e.nzp));
        if (e.m[5]) chk({e.nm, ".busy_vec"}, 32'(e.sel_b ? {2'b00, b_busy_vec} : a_busy_vec), 32'(e.bv));
      end
    end
  end

  // Monitor for instance C: every queued cycle checks all outputs
  initial begin
    cexp_t e;
    forever begin
      @(negedge clk);
      if (q_c.size() > 0) begin
        e = q_c.pop_front();
        chk("rand.d1", c_rd_data1, e.d1);
        chk("rand.d2", c_rd_data2, e.d2);
        chk("rand.busy1", 32'(c_rd_busy1), 32'(e.b1));
        chk("rand.busy2", 32'(c_rd_busy2), 32'(e.b2));
        chk("rand.nzp", 32'(c_nzp), 32'(e.nzp));
        chk("rand.busy_vec", 32'(c_busy_vec), 32'(e.bv));
      end
    end
  end

  // Reference model for instance C
  logic [31:0] m_mem [16];
  logic [15:0] m_busy;
  logic [2:0]  m_nzp;

  initial begin
    cexp_t ce;
    // ---------------- reset and read-all ----------------
    drv(0, 0, 0, 16'h0, 0, 0, 0, 0, 1);
    exp_ab("rst0", 0, M_D1 | M_D2 | M_NZP | M_BV, 16'h0, 16'h0, 0, 0, 3'b010, 8'h00);
    drv(0, 0, 0, 16'h0, 0, 0, 0, 2, 3);
    exp_ab("rst1", 0, M_D1 | M_D2 | M_B1 | M_B2 | M_NZP | M_BV, 16'h0, 16'h0, 0, 0, 3'b010, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 0, 16'h0, 0, 0, 0, 3'(2 * i), 3'(2 * i + 1));
      exp_ab("rd_all", 0, M_D1 | M_D2, 16'h0, 16'h0, 0, 0, 3'b000, 8'h00);
    end
    // ---------------- reset overriding a write ----------------
    drv(0, 1, 3, 16'h1234, 1, 1, 3, 3, 4);
    exp_ab("rst_byp", 0, M_D1 | M_D2 | M_NZP | M_BV, 16'h1234, 16'h0, 0, 0, 3'b010, 8'h00);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 3, 3);
    exp_ab("rst_mid_wr", 0, M_D1 | M_B1 | M_NZP | M_BV, 16'h0, 16'h0, 0, 0, 3'b010, 8'h00);
    // ---------------- write / bypass / array ----------------
    drv(1, 1, 5, 16'hBEEF, 0, 0, 0, 5, 5);
    exp_ab("wr5_byp", 0, M_D1 | M_D2, 16'hBEEF, 16'hBEEF, 0, 0, 3'b000, 8'h00);
    drv(1, 1, 6, 16'h6666, 0, 0, 0, 5, 6);
    exp_ab("wr6_byp", 0, M_D1 | M_D2, 16'hBEEF, 16'h6666, 0, 0, 3'b000, 8'h00);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 6, 5);
    exp_ab("rd56", 0, M_D1 | M_D2, 16'h6666, 16'hBEEF, 0, 0, 3'b000, 8'h00);
    // ---------------- scoreboard ----------------
    drv(1, 0, 0, 16'h0, 0, 1, 2, 2, 2);
    exp_ab("iss_t0", 0, M_B1 | M_B2 | M_BV, 16'h0, 16'h0, 0, 0, 3'b000, 8'h00);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 2, 3);
    exp_ab("iss_t1", 0, M_B1 | M_B2 | M_BV, 16'h0, 16'h0, 1, 0, 3'b000, 8'h04);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 2, 2);
    exp_ab("iss_t2", 0, M_B1 | M_B2, 16'h0, 16'h0, 1, 1, 3'b000, 8'h00);
    drv(1, 1, 2, 16'h00A5, 0, 0, 0, 2, 3);
    exp_ab("wb_t3", 0, M_D1 | M_B1 | M_BV, 16'h00A5, 16'h0, 0, 0, 3'b000, 8'h04);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 2, 2);
    exp_ab("wb_t4", 0, M_D1 | M_B1 | M_BV, 16'h00A5, 16'h0, 0, 0, 3'b000, 8'h00);
    drv(1, 0, 0, 16'h0, 0, 1, 2, 2, 2);
    drv(1, 1, 2, 16'h1111, 0, 1, 2, 2, 2);
    exp_ab("iss_wb_same", 0, M_D1 | M_B1 | M_BV, 16'h1111, 16'h0, 0, 0, 3'b000, 8'h04);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 2, 2);
    exp_ab("iss_wins", 0, M_D1 | M_B1 | M_BV, 16'h1111, 16'h0, 1, 0, 3'b000, 8'h04);
    drv(1, 1, 2, 16'h2222, 0, 0, 0, 2, 2);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 2, 2);
    exp_ab("wb_clear", 0, M_D1 | M_B1 | M_BV, 16'h2222, 16'h0, 0, 0, 3'b000, 8'h00);
    // ---------------- NZP ----------------
    drv(1, 1, 1, 16'h8000, 1, 0, 0, 0, 0);
    exp_ab("nzp_pre", 0, M_NZP, 16'h0, 16'h0, 0, 0, 3'b010, 8'h00);
    drv(1, 1, 1, 16'h0000, 1, 0, 0, 0, 0);
    exp_ab("nzp_neg", 0, M_NZP, 16'h0, 16'h0, 0, 0, 3'b100, 8'h00);
    drv(1, 1, 1, 16'h0001, 1, 0, 0, 0, 0);
    exp_ab("nzp_zero", 0, M_NZP, 16'h0, 16'h0, 0, 0, 3'b010, 8'h00);
    drv(1, 1, 1, 16'h8000, 0, 0, 0, 0, 0);
    exp_ab("nzp_pos", 0, M_NZP, 16'h0, 16'h0, 0, 0, 3'b001, 8'h00);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 1, 0);
    exp_ab("nzp_hold", 0, M_D1 | M_NZP, 16'h8000, 16'h0, 0, 0, 3'b001, 8'h00);
    // ---------------- non-power-of-two instance ----------------
    drv(1, 1, 7, 16'h8001, 1, 1, 7, 6, 5);
    exp_ab("np2_rd6", 1, M_D1 | M_D2 | M_B1 | M_B2 | M_NZP | M_BV, 16'h0, 16'hBEEF, 0, 0, 3'b001, 8'h00);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 7, 0);
    exp_ab("np2_after", 1, M_D1 | M_D2 | M_B1 | M_NZP | M_BV, 16'h0, 16'h0, 0, 0, 3'b100, 8'h00);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 1, 2);
    exp_ab("np2_r12", 1, M_D1 | M_D2, 16'h8000, 16'h2222, 0, 0, 3'b000, 8'h00);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 3, 4);
    exp_ab("np2_r34", 1, M_D1 | M_D2, 16'h0, 16'h0, 0, 0, 3'b000, 8'h00);
    drv(1, 0, 0, 16'h0, 0, 0, 0, 7, 7);
    exp_ab("a_r7", 0, M_D1 | M_B1 | M_BV, 16'h8001, 16'h0, 1, 0, 3'b000, 8'h80);
    // ---------------- 16x32 reference-model sweep ----------------
    @(posedge clk); #1; c_rst_n = 1'b0;
    @(posedge clk); #1; c_rst_n = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_busy = '0;
    m_nzp  = 3'b010;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clk);
      #1;
      c_rst_n    = 1'b1;
      c_wr_en    = ($urandom_range(0, 1) == 1);
      c_wr_addr  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       c_wr_data = 32'h0;
        1:       c_wr_data = 32'h8000_0000 | $urandom;
        default: c_wr_data = $urandom;
      endcase
      c_cc_en    = ($urandom_range(0, 1) == 1);
      c_issue_en = ($urandom_range(0, 3) == 0);
      c_issue_dr = 4'($urandom_range(0, 15));
      c_rd_addr1 = 4'($urandom_range(0, 15));
      c_rd_addr2 = (cyc % 7 == 0) ? c_wr_addr : 4'($urandom_range(0, 15));
      ce.d1  = (c_wr_en && c_wr_addr == c_rd_addr1) ? c_wr_data : m_mem[c_rd_addr1];
      ce.d2  = (c_wr_en && c_wr_addr == c_rd_addr2) ? c_wr_data : m_mem[c_rd_addr2];
      ce.b1  = m_busy[c_rd_addr1] && !(c_wr_en && c_wr_addr == c_rd_addr1);
      ce.b2  = m_busy[c_rd_addr2] && !(c_wr_en && c_wr_addr == c_rd_addr2);
      ce.nzp = m_nzp;
      ce.bv  = m_busy;
      q_c.push_back(ce);
      if (c_wr_en) begin
        m_mem[c_wr_addr] = c_wr_data;
        m_busy[c_wr_addr] = 1'b0;
        if (c_cc_en) begin
          if (c_wr_data[31])          m_nzp = 3'b100;
          else if (c_wr_data == 32'h0) m_nzp = 3'b010;
          else                         m_nzp = 3'b001;
        end
      end
      if (c_issue_en) m_busy[c_issue_dr] = 1'b1;
    end
    @(posedge clk); #1;
    c_wr_en = 1'b0; c_issue_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("queues_drained", 32'(q_ab.size() + q_c.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
